rca_40b_seq_ctrl: RTL and testbench
===================================

Name: rca_40b_seq_ctrl

Overview:
- Sequencer that computes a 40-bit add (A + B + Cin) over several cycles using one shared 8-bit ripple-carry slice.
- The carry is registered between slices.
- Replaces the five-slice parallel 40-bit RCA where area matters more than latency.
- Sits between a valid/ready producer and a valid/ready consumer, and owns operand latching, slice indexing, carry hand-off and result assembly.

Parameters:
- SLICE_W, 8, width of the shared ripple slice in bits.
- NUM_SLICES, 5, number of slice passes; operand width W = SLICE_W*NUM_SLICES (default 40).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  controller can accept operands.
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry-in for slice 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  W  registered result.
- cout  out  1  carry out of the top slice.
- busy  out  1  high in RUN.

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n low forces state IDLE immediately, independent of clk.
- Reset values:
  - state=IDLE, slice index idx=0, carry reg=0.
  - Operand regs=0, sum=0, cout=0.
  - out_valid=0, busy=0, in_ready=1 (in_ready is decoded from state).
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: latch a, b; carry reg<=cin; idx<=0; sum<=0; cout<=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: shared slice adds A[idx], B[idx] (SLICE_W-bit fields) and the carry reg.
  - The slice result is written to sum[idx*SLICE_W +: SLICE_W]; carry reg<=slice carry-out; idx<=idx+1.
  - On the edge where idx==NUM_SLICES-1: also cout<=slice carry-out, idx<=0, go to DONE.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_valid&&out_ready at an edge: go to IDLE.
  - in_ready=0 throughout DONE; there is no same-cycle accept of a new request.
- Latency:
  - Accept at edge k; slices computed at edges k+1..k+NUM_SLICES.
  - out_valid high after edge k+NUM_SLICES (5 cycles default).
  - Minimum initiation interval is NUM_SLICES+2 cycles.
- Arithmetic: unsigned modulo 2^W. Carry propagates strictly slice 0 to slice NUM_SLICES-1 through the registered carry. There is no combinational path from a/b/cin to sum.
- Input stability: a, b, cin and in_valid are ignored outside IDLE. The latched copies are used, so the producer may change inputs after the handshake.
- out_ready asserted while out_valid=0 has no effect.
- Partial sum bits are visible during RUN but are not valid until out_valid.
- Reset mid-RUN or mid-DONE: transaction discarded, all outputs return to reset values, no result emitted. The next request after reset completes correctly.
- idx never exceeds NUM_SLICES-1; no wrap beyond the last slice.

Optional Feature:
- Macro SEQ_OVF_EN.
- When defined:
  - Extra output port ovf (out, 1): signed two's-complement overflow = (carry into MSB) XOR (carry out of MSB).
  - Captured on the final RUN edge and held in DONE with sum.
  - Reset value 0; cleared on accept.
- When undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 -> out_valid=0, busy=0, sum=0, cout=0, in_ready=1. Assert rst_n=0 asynchronously mid-cycle -> same values without a clock edge.
- a=0x00000000FF, b=0x0000000001, cin=0 -> sum=0x0000000100, cout=0; out_valid rises exactly 5 cycles after the accept edge; busy high for 5 cycles.
- a=0xFFFFFFFFFF, b=0x0000000000, cin=1 -> sum=0x0000000000, cout=1. Carry ripples through all 5 slices; check the intermediate carry reg=1 each RUN cycle.
- Backpressure: complete a=0x123456789A, b=0x0101010101 (sum=0x133557799B) with out_ready=0 for 3 cycles -> sum/out_valid stable, in_ready=0. New in_valid with other data is ignored. After out_ready=1, back to IDLE the next cycle.
- Reset during RUN at idx=2 -> IDLE, out_valid never asserted. Next request a=0x0000000001, b=0x0000000001 -> sum=0x0000000002, cout=0.
- SEQ_OVF_EN defined: a=0x7FFFFFFFFF, b=0x0000000001 -> sum=0x8000000000, cout=0, ovf=1. Then a=0xFFFFFFFFFF, b=0x0000000001 -> ovf=0, cout=1. Macro undefined: build has no ovf port.

Source files
------------

// File: rtl/rca_40b_seq_ctrl.sv
// rca_40b_seq_ctrl: multi-cycle W-bit adder (A+B+cin) built on one shared
// SLICE_W ripple slice, with the carry registered between slice passes.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready, a, b, cin (request);
//        out_valid/out_ready, sum, cout (result); busy (high while slicing).
// Option: define SEQ_OVF_EN to add output ovf (signed overflow of the result).
module rca_40b_seq_ctrl #(
  parameter int SLICE_W    = 8,
  parameter int NUM_SLICES = 5,
  parameter int W          = SLICE_W * NUM_SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
`ifdef SEQ_OVF_EN
  output logic         ovf,
`endif
  output logic         busy
);

  localparam int IW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [IW-1:0]       idx;
  logic                carry;
  logic [W-1:0]        opa;
  logic [W-1:0]        opb;

  logic [SLICE_W-1:0]  sl_a;
  logic [SLICE_W-1:0]  sl_b;
  logic [SLICE_W:0]    sl_res;
  logic                sl_last;

  assign sl_a    = opa[idx*SLICE_W +: SLICE_W];
  assign sl_b    = opb[idx*SLICE_W +: SLICE_W];
  assign sl_res  = {1'b0, sl_a} + {1'b0, sl_b}
                 + {{SLICE_W{1'b0}}, carry};
  assign sl_last = (idx == LAST);

`ifdef SEQ_OVF_EN
  // Carry into the MSB falls out of the MSB sum bit: s = a ^ b ^ cin.
  logic msb_cin;
  assign msb_cin = sl_a[SLICE_W-1] ^ sl_b[SLICE_W-1]
                 ^ sl_res[SLICE_W-1];
`endif

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      opa       <= '0;
      opb       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SEQ_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b1;
`ifdef SEQ_OVF_EN
            ovf   <= 1'b0;
`endif
            state <= RUN;
          end
        end
        RUN: begin
          sum[idx*SLICE_W +: SLICE_W] <= sl_res[SLICE_W-1:0];
          carry <= sl_res[SLICE_W];
          if (sl_last) begin
            cout      <= sl_res[SLICE_W];
            idx       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
`ifdef SEQ_OVF_EN
            ovf       <= msb_cin ^ sl_res[SLICE_W];
`endif
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_40b_seq_ctrl.sv
// tb_rca_40b_seq_ctrl: directed bench for the sequential 40-bit adder.
// Vectors and expected sums are hand-computed constants.
module tb_rca_40b_seq_ctrl;

  localparam int W = 40;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SEQ_OVF_EN
  logic         ovf;
`endif

  int checks;
  int failures;

  rca_40b_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_rst(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".busy"},      64'(busy),      64'd0);
    chk({tag, ".sum"},       64'(sum),       64'd0);
    chk({tag, ".cout"},      64'(cout),      64'd0);
    chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
  endtask

  // Present a request; returns just after the accept edge.
  task automatic start(input logic [W-1:0] va,
                       input logic [W-1:0] vb,
                       input logic vc);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = '1;
    b        = '1;
    cin      = ~vc;
    chk("acc.busy",     64'(busy),     64'd1);
    chk("acc.in_ready", 64'(in_ready), 64'd0);
  endtask

  // Five slice edges; out_valid must appear exactly after the fifth.
  task automatic run_to_done(input string tag,
                             input logic [W-1:0] esum,
                             input logic ecout,
                             input bit chk_carry);
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (chk_carry)
        chk({tag, ".carry"}, 64'(dut.carry), 64'd1);
      if (i < 5) begin
        chk({tag, ".ov_lo"}, 64'(out_valid), 64'd0);
        chk({tag, ".busy1"}, 64'(busy),      64'd1);
      end else begin
        chk({tag, ".ov_hi"}, 64'(out_valid), 64'd1);
        chk({tag, ".busy0"}, 64'(busy),      64'd0);
        chk({tag, ".sum"},   64'(sum),       64'(esum));
        chk({tag, ".cout"},  64'(cout),      64'(ecout));
      end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;

    tick();
    tick();
    chk_idle_rst("rst");
    #2 rst_n = 1'b1;
    tick();

    // 0xFF + 0x01: carry out of slice 0 into slice 1.
    start(40'h00000000FF, 40'h0000000001, 1'b0);
    run_to_done("t1", 40'h0000000100, 1'b0, 1'b0);
    tick();
    chk("t1.ov_clr", 64'(out_valid), 64'd0);
    chk("t1.rdy",    64'(in_ready),  64'd1);

    // All-ones + cin: carry ripples through every slice.
    start(40'hFFFFFFFFFF, 40'h0000000000, 1'b1);
    chk("t2.carry0", 64'(dut.carry), 64'd1);
    run_to_done("t2", 40'h0000000000, 1'b1, 1'b1);
    tick();

    // Backpressure with a competing request held off.
    out_ready = 1'b0;
    start(40'h123456789A, 40'h0101010101, 1'b0);
    run_to_done("t3", 40'h133557799B, 1'b0, 1'b0);
    a        = 40'h1111111111;
    b        = 40'h2222222222;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3.hold_ov",  64'(out_valid), 64'd1);
      chk("t3.hold_sum", 64'(sum),       64'h133557799B);
      chk("t3.hold_rdy", 64'(in_ready),  64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3.rel_ov",  64'(out_valid), 64'd0);
    chk("t3.rel_rdy", 64'(in_ready),  64'd1);
    chk("t3.rel_sum", 64'(sum),       64'h133557799B);

    // Async reset mid-RUN at idx=2, then a fresh request.
    start(40'hFFFFFFFFFF, 40'h0000000001, 1'b0);
    tick();
    tick();
    chk("t4.idx", 64'(dut.idx), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_rst("t4.async");
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t4.no_ov", 64'(out_valid), 64'd0);
    end
    #2 rst_n = 1'b1;
    tick();
    start(40'h0000000001, 40'h0000000001, 1'b0);
    run_to_done("t5", 40'h0000000002, 1'b0, 1'b0);
    tick();

`ifdef SEQ_OVF_EN
    start(40'h7FFFFFFFFF, 40'h0000000001, 1'b0);
    chk("ovf.clr", 64'(ovf), 64'd0);
    run_to_done("ovf1", 40'h8000000000, 1'b0, 1'b0);
    chk("ovf1.ovf", 64'(ovf), 64'd1);
    tick();
    start(40'hFFFFFFFFFF, 40'h0000000001, 1'b0);
    chk("ovf.clr2", 64'(ovf), 64'd0);
    run_to_done("ovf2", 40'h0000000000, 1'b1, 1'b0);
    chk("ovf2.ovf", 64'(ovf), 64'd0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
